// File: rtl/ntt_stream_buffer_if.sv
// Stream-side and wrapper-side signal bundle for ntt_stream_buffer.
// slave = the buffer itself, master = whoever drives the streams and the wrapper.
interface ntt_stream_buffer_if #(
    parameter int LOGQ = 60,
    parameter int LOGN = 10
);
    localparam int AW = ((LOGN < 9) ? 9 : LOGN) + 1;

    logic            in_valid;
    logic            in_ready;
    logic [LOGQ-1:0] in_data;
    logic            intt_in;
    logic            ntt_clear;
    logic            ntt_start;
    logic            ntt_intt;
    logic [AW-1:0]   ntt_rd_addr;
    logic [LOGQ-1:0] ntt_data;
    logic [AW-1:0]   ntt_wr_addr;
    logic            ntt_wea;
    logic [LOGQ-1:0] ntt_result;
    logic            ntt_finish;
    logic            out_valid;
    logic            out_ready;
    logic [LOGQ-1:0] out_data;
    logic            busy;
    logic            done;

    modport slave (
        input  in_valid, in_data, intt_in, ntt_rd_addr, ntt_wr_addr, ntt_wea,
               ntt_result, ntt_finish, out_ready,
        output in_ready, ntt_clear, ntt_start, ntt_intt, ntt_data, out_valid,
               out_data, busy, done
    );

    modport master (
        output in_valid, in_data, intt_in, ntt_rd_addr, ntt_wr_addr, ntt_wea,
               ntt_result, ntt_finish, out_ready,
        input  in_ready, ntt_clear, ntt_start, ntt_intt, ntt_data, out_valid,
               out_data, busy, done
    );
endinterface

// File: rtl/ntt_stream_buffer.sv
// Loads one polynomial into bank A, runs the NTT wrapper against A/B,
// then drains bank B in natural order through a two-deep output skid.
//
//  state   | meaning
//  S_IDLE  | waiting for first input word, wrapper held in clear
//  S_LOAD  | accepting words 1..N-1 into bank A
//  S_CLEAR | one extra clear cycle before start
//  S_RUN   | wrapper running: serves reads from A, captures writes into B
//  S_DRAIN | streaming B[0..N-1] out
module ntt_stream_buffer #(
    parameter int LOGQ   = 60,
    parameter int LOGN   = 10,
    parameter int RD_LAT = 2
) (
    input logic              clk,
    input logic              rst,
    ntt_stream_buffer_if.slave bus
);
    localparam int N  = 1 << LOGN;
    localparam int AW = ((LOGN < 9) ? 9 : LOGN) + 1;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CLEAR, S_RUN, S_DRAIN} state_t;

    state_t          state_q, state_d;
    logic [LOGN-1:0] cnt_q;
    logic [LOGN-1:0] rd_idx_q;
    logic            fetch_done_q;
    logic            in_ready_q, clear_q, start_q, intt_q, busy_q, done_q;
    logic            v1_q, out_valid_q;
    logic [LOGQ-1:0] b_rdata_q, out_data_q;
    logic [LOGQ-1:0] bank_a [N];
    logic [LOGQ-1:0] bank_b [N];
    logic [LOGQ-1:0] rd_pipe_q [RD_LAT];

    logic in_hs, out_hs, move1, issue, last_in, last_out;

    assign in_hs    = rst && bus.in_valid && in_ready_q;
    assign out_hs   = out_valid_q && bus.out_ready;
    // Stage 1 (RAM output register) may advance whenever the holding register frees up.
    assign move1    = v1_q && (!out_valid_q || out_hs);
    assign issue    = (state_q == S_DRAIN) && !fetch_done_q && (!v1_q || move1);
    assign last_in  = in_hs && (cnt_q == LOGN'(N - 1));
    assign last_out = out_hs && (cnt_q == LOGN'(N - 1));

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (in_hs)          state_d = S_LOAD;
            S_LOAD:  if (last_in)        state_d = S_CLEAR;
            S_CLEAR:                     state_d = S_RUN;
            S_RUN:   if (bus.ntt_finish) state_d = S_DRAIN;
            S_DRAIN: if (last_out)       state_d = S_IDLE;
            default:                     state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            rd_idx_q     <= '0;
            fetch_done_q <= 1'b0;
            in_ready_q   <= 1'b0;
            clear_q      <= 1'b1;
            start_q      <= 1'b0;
            intt_q       <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            v1_q         <= 1'b0;
            out_valid_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d == S_IDLE) || (state_d == S_LOAD);
            clear_q    <= (state_d == S_IDLE) || (state_d == S_LOAD) || (state_d == S_CLEAR);
            start_q    <= (state_d == S_RUN);
            busy_q     <= (state_d != S_IDLE);
            done_q     <= (state_q == S_DRAIN) && last_out;
            if (state_q == S_IDLE && in_hs) intt_q <= bus.intt_in;

            if (state_q == S_RUN)        cnt_q <= '0;
            else if (in_hs || out_hs)    cnt_q <= cnt_q + 1'b1;

            if (state_q != S_DRAIN) begin
                rd_idx_q     <= '0;
                fetch_done_q <= 1'b0;
                v1_q         <= 1'b0;
                out_valid_q  <= 1'b0;
            end else begin
                if (issue) begin
                    rd_idx_q <= rd_idx_q + 1'b1;
                    if (rd_idx_q == LOGN'(N - 1)) fetch_done_q <= 1'b1;
                end
                if (issue)      v1_q <= 1'b1;
                else if (move1) v1_q <= 1'b0;
                if (move1)       out_valid_q <= 1'b1;
                else if (out_hs) out_valid_q <= 1'b0;
            end
        end
    end

    // Banks and read pipeline carry no reset; stale contents are never observed.
    always_ff @(posedge clk) begin
        if (in_hs) bank_a[cnt_q] <= bus.in_data;
        rd_pipe_q[0] <= (bus.ntt_rd_addr[AW-1:LOGN] == '0) ?
                        bank_a[bus.ntt_rd_addr[LOGN-1:0]] : '0;
        for (int i = 1; i < RD_LAT; i++) rd_pipe_q[i] <= rd_pipe_q[i-1];
        if (state_q == S_RUN && bus.ntt_wea && bus.ntt_wr_addr[AW-1:LOGN] == '0)
            bank_b[bus.ntt_wr_addr[LOGN-1:0]] <= bus.ntt_result;
        if (issue) b_rdata_q  <= bank_b[rd_idx_q];
        if (move1) out_data_q <= b_rdata_q;
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.ntt_clear = clear_q;
    assign bus.ntt_start = start_q;
    assign bus.ntt_intt  = intt_q;
    assign bus.ntt_data  = rd_pipe_q[RD_LAT-1];
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_ntt_stream_buffer.sv
// Bench for ntt_stream_buffer with a behavioural stand-in for the NTT wrapper:
// the stand-in writes B[bitrev(i)] = A[i] ^ KEY, so a forward+inverse pass is an identity.
module tb_ntt_stream_buffer;
    localparam int LOGQ = 60, LOGN = 4, RD_LAT = 2, N = 16, AW = 10;
    localparam logic [LOGQ-1:0] KEY = 60'h5A3_C0FF_EE12_3456;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    ntt_stream_buffer_if #(.LOGQ(LOGQ), .LOGN(LOGN)) bus ();
    ntt_stream_buffer #(.LOGQ(LOGQ), .LOGN(LOGN), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    logic [LOGQ-1:0] poly_in [N];
    logic [LOGQ-1:0] exp_out [N];
    logic [LOGQ-1:0] got     [N];
    logic [LOGQ-1:0] fwd_out [N];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] bitrev(input logic [3:0] v);
        return {v[0], v[1], v[2], v[3]};
    endfunction

    // Reference: output index k holds input index bitrev(k), xored with KEY.
    task automatic model_forward();
        for (int k = 0; k < N; k++) exp_out[k] = poly_in[bitrev(4'(k))] ^ KEY;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"},  64'(bus.in_ready),  64'd0);
        check({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
        check({tag, "_clear"},     64'(bus.ntt_clear), 64'd1);
        check({tag, "_start"},     64'(bus.ntt_start), 64'd0);
        check({tag, "_done"},      64'(bus.done),      64'd0);
        check({tag, "_busy"},      64'(bus.busy),      64'd0);
    endtask

    // mode 0: in_valid tied 1, 1: toggling 1010, 2: tied 1 and kept high afterwards
    task automatic load_poly(input int mode, input logic intt);
        int idx = 0;
        int cyc = 0;
        while (idx < N && cyc < 400) begin
            @(posedge clk); #1;
            bus.in_valid = (mode == 1) ? (cyc % 2 == 0) : 1'b1;
            bus.in_data  = poly_in[idx];
            bus.intt_in  = (idx == 0) ? intt : ~intt;
            @(negedge clk);
            if (bus.in_valid && bus.in_ready) idx++;
            cyc++;
        end
        check("load_count", 64'(idx), 64'(N));
        @(posedge clk); #1;
        bus.in_valid = (mode == 2);
        bus.in_data  = '1;
        @(negedge clk);
        check("clear_state_in_ready", 64'(bus.in_ready),  64'd0);
        check("clear_state_clear",    64'(bus.ntt_clear), 64'd1);
        check("clear_state_start",    64'(bus.ntt_start), 64'd0);
    endtask

    task automatic run_wrapper(input logic exp_intt, input bit illegal);
        int seq [N+2];
        int cyc = 0;
        bit seen = 0;
        while (!seen && cyc < 10) begin
            @(negedge clk);
            seen = bus.ntt_start;
            cyc++;
        end
        check("start_seen", 64'(seen), 64'd1);
        check("run_clear",  64'(bus.ntt_clear), 64'd0);
        check("run_intt",   64'(bus.ntt_intt),  64'(exp_intt));
        for (int i = 0; i < N; i++) seq[i] = i;
        seq[N]   = 5;
        seq[N+1] = 16;
        for (int c = 0; c < N + 2 + RD_LAT; c++) begin
            int j;
            j = c - RD_LAT;
            @(posedge clk); #1;
            bus.ntt_rd_addr = (c < N + 2) ? AW'(seq[c]) : '0;
            bus.ntt_wea     = 1'b0;
            if (j >= 0 && j < N) begin
                bus.ntt_wea     = 1'b1;
                bus.ntt_wr_addr = AW'(bitrev(4'(j)));
                bus.ntt_result  = poly_in[j] ^ KEY;
            end else if (j >= 0 && seq[j] >= N) begin
                bus.ntt_wea     = 1'b1;
                bus.ntt_wr_addr = AW'(16);
                bus.ntt_result  = '1;
            end
            @(negedge clk);
            if (j >= 0)
                check($sformatf("rd_data_addr%0d", seq[j]), 64'(bus.ntt_data),
                      (seq[j] < N) ? 64'(poly_in[seq[j]]) : 64'd0);
            if (illegal) check("in_ready_run", 64'(bus.in_ready), 64'd0);
        end
        @(posedge clk); #1;
        bus.ntt_wea    = 1'b0;
        bus.ntt_finish = 1'b1;
        @(negedge clk);
        check("start_held", 64'(bus.ntt_start), 64'd1);
        @(posedge clk); #1;
        bus.ntt_finish = 1'b0;
        @(negedge clk);
        check("start_dropped", 64'(bus.ntt_start), 64'd0);
    endtask

    // rmode 0: out_ready tied 1, 1: random 50%; stop_after < N leaves the drain unfinished
    task automatic drain(input int rmode, input bit illegal, input int stop_after);
        int idx = 0;
        int cyc = 0;
        int first_hs = -1;
        int last_hs = 0;
        bit prev_stall = 0;
        logic [LOGQ-1:0] prev_data = '0;
        while (idx < stop_after && cyc < 2000) begin
            @(posedge clk); #1;
            bus.out_ready = (rmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            if (illegal) begin
                bus.ntt_wea     = 1'b1;
                bus.ntt_wr_addr = AW'(cyc % N);
                bus.ntt_result  = '1;
            end
            @(negedge clk);
            if (prev_stall) check("out_stable", 64'(bus.out_data), 64'(prev_data));
            check("no_early_done", 64'(bus.done), 64'd0);
            if (illegal) check("in_ready_drain", 64'(bus.in_ready), 64'd0);
            if (bus.out_valid && bus.out_ready) begin
                got[idx] = bus.out_data;
                check($sformatf("out_word%0d", idx), 64'(bus.out_data), 64'(exp_out[idx]));
                if (first_hs < 0) first_hs = cyc;
                last_hs = cyc;
                idx++;
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_data  = bus.out_data;
            cyc++;
        end
        if (stop_after == N) begin
            check("drain_count", 64'(idx), 64'(N));
            if (rmode == 0) check("zero_bubble", 64'(last_hs - first_hs), 64'(N - 1));
            @(posedge clk); #1;
            bus.out_ready = 1'b0;
            bus.ntt_wea   = 1'b0;
            bus.in_valid  = 1'b0;
            @(negedge clk);
            check("done_pulse",      64'(bus.done),      64'd1);
            check("busy_after",      64'(bus.busy),      64'd0);
            check("out_valid_after", 64'(bus.out_valid), 64'd0);
            @(negedge clk);
            check("done_once", 64'(bus.done), 64'd0);
        end
    endtask

    task automatic pulse_reset(input string tag);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            @(negedge clk);
            check_reset_outputs(tag);
        end
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check({tag, "_post_done"}, 64'(bus.done), 64'd0);
            check({tag, "_post_busy"}, 64'(bus.busy), 64'd0);
        end
        check({tag, "_idle_ready"}, 64'(bus.in_ready), 64'd1);
    endtask

    initial begin
        bus.in_valid = 0; bus.in_data = '0; bus.intt_in = 0; bus.ntt_rd_addr = '0;
        bus.ntt_wr_addr = '0; bus.ntt_wea = 0; bus.ntt_result = '0; bus.ntt_finish = 0;
        bus.out_ready = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("por");
        check("por_intt", 64'(bus.ntt_intt), 64'd0);
        rst = 1'b1;
        @(negedge clk);
        check("idle_in_ready", 64'(bus.in_ready), 64'd1);

        // Reset in the middle of LOAD
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            bus.in_valid = 1'b1;
            bus.in_data  = LOGQ'($urandom);
        end
        @(negedge clk);
        check("mid_load_busy", 64'(bus.busy), 64'd1);
        pulse_reset("rst_load");

        // Forward transform, ideal streams
        for (int i = 0; i < N; i++) poly_in[i] = LOGQ'(i);
        model_forward();
        load_poly(0, 1'b0);
        run_wrapper(1'b0, 1'b0);
        drain(0, 1'b0, N);
        for (int i = 0; i < N; i++) fwd_out[i] = got[i];

        // Reset in the middle of DRAIN
        for (int i = 0; i < N; i++) poly_in[i] = {LOGQ'($urandom), 28'($urandom)};
        model_forward();
        load_poly(1, 1'b0);
        run_wrapper(1'b0, 1'b0);
        drain(1, 1'b0, 5);
        pulse_reset("rst_drain");

        // Inverse round trip returns the original 0..N-1
        for (int i = 0; i < N; i++) begin
            poly_in[i] = fwd_out[i];
            exp_out[i] = LOGQ'(i);
        end
        load_poly(0, 1'b1);
        run_wrapper(1'b1, 1'b0);
        drain(0, 1'b0, N);

        // Bubbles on input, random backpressure on output
        for (int i = 0; i < N; i++) poly_in[i] = LOGQ'(i);
        model_forward();
        load_poly(1, 1'b0);
        run_wrapper(1'b0, 1'b0);
        drain(1, 1'b0, N);

        // Illegal traffic: in_valid held through RUN/DRAIN, stray wrapper writes
        load_poly(2, 1'b0);
        run_wrapper(1'b0, 1'b1);
        drain(1, 1'b1, N);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
